tiny8_control: RTL and testbench

- Multi-cycle control FSM for the tiny8 CPU.
- Sequences fetch/decode/execute over the instruction register, PC, register file and a single shared memory port.
- Consumes the IR's decoded opcode and imm4 fields plus the datapath zero flag.
- Produces all load/mux/memory-request strobes. One instruction in flight; no pipelining.

---
 rtl/tiny8_control.sv | 144 ++++++++++++++
 tb/tb_tiny8_control.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/tiny8_control.sv
// tiny8_control: multi-cycle fetch/decode/execute sequencer for the tiny8 CPU.
// One instruction in flight; a single shared memory port with a request/response handshake.
// Optional feature macro: TINY8_CTRL_HALT_EN (branch-to-self with Z set parks the core in HALT).
module tiny8_control (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] opcode,
  input  logic [3:0] imm4,
  input  logic       z_flag,
  input  logic       mem_resp,
  output logic       mem_read,
  output logic       mem_write,
  output logic       addr_sel,
  output logic       load_ir,
  output logic       load_pc,
  output logic       pc_sel,
  output logic       load_reg,
  output logic       reg_sel,
  output logic       instr_done,
  output logic       halted
);

  typedef enum logic [2:0] {
    StFetch,
    StDecode,
    StExecAdd,
    StExecLd,
    StExecSt,
    StExecBr
`ifdef TINY8_CTRL_HALT_EN
    , StHalt
`endif
  } state_e;

  state_e state_q, state_d;

`ifdef TINY8_CTRL_HALT_EN
  logic br_self;
  assign br_self = z_flag && (imm4 == 4'hF);
`else
  // imm4 only matters for halt detection; keep it visibly consumed.
  logic unused_imm4;
  assign unused_imm4 = ^imm4;
`endif

  // Next-state selection; mem_resp only advances states that own a memory request.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFetch:   if (mem_resp) state_d = StDecode;
      StDecode: begin
        unique case (opcode)
          2'b00:   state_d = StExecAdd;
          2'b01:   state_d = StExecLd;
          2'b10:   state_d = StExecSt;
          default: state_d = StExecBr;
        endcase
      end
      StExecAdd: state_d = StFetch;
      StExecLd:  if (mem_resp) state_d = StFetch;
      StExecSt:  if (mem_resp) state_d = StFetch;
      StExecBr: begin
`ifdef TINY8_CTRL_HALT_EN
        state_d = br_self ? StHalt : StFetch;
`else
        state_d = StFetch;
`endif
      end
`ifdef TINY8_CTRL_HALT_EN
      StHalt:    state_d = StHalt;
`endif
      default:   state_d = StFetch;
    endcase
  end

  // State register; async reset drops any in-flight request and restarts at fetch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  // Strobe decode from state (plus mem_resp in wait states); forced quiet while rst is high.
  always_comb begin
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    addr_sel   = 1'b0;
    load_ir    = 1'b0;
    load_pc    = 1'b0;
    pc_sel     = 1'b0;
    load_reg   = 1'b0;
    reg_sel    = 1'b0;
    instr_done = 1'b0;
    halted     = 1'b0;
    if (!rst) begin
      unique case (state_q)
        StFetch: begin
          mem_read = 1'b1;
          if (mem_resp) begin
            load_ir = 1'b1;
            load_pc = 1'b1;
          end
        end
        StDecode: ;
        StExecAdd: begin
          load_reg   = 1'b1;
          instr_done = 1'b1;
        end
        StExecLd: begin
          mem_read = 1'b1;
          addr_sel = 1'b1;
          if (mem_resp) begin
            load_reg   = 1'b1;
            reg_sel    = 1'b1;
            instr_done = 1'b1;
          end
        end
        StExecSt: begin
          mem_write = 1'b1;
          addr_sel  = 1'b1;
          if (mem_resp) instr_done = 1'b1;
        end
        StExecBr: begin
          instr_done = 1'b1;
`ifdef TINY8_CTRL_HALT_EN
          if (z_flag && !br_self) begin
`else
          if (z_flag) begin
`endif
            load_pc = 1'b1;
            pc_sel  = 1'b1;
          end
        end
`ifdef TINY8_CTRL_HALT_EN
        StHalt: halted = 1'b1;
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tiny8_control.sv
// Self-checking bench for tiny8_control: per-cycle expected strobe vectors go through a
// scoreboard queue and are compared against the DUT outputs at the falling edge.
module tb_tiny8_control;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] opcode = 2'b00;
  logic [3:0] imm4 = 4'h0;
  logic       z_flag = 1'b0;
  logic       mem_resp = 1'b0;
  logic mem_read, mem_write, addr_sel, load_ir, load_pc, pc_sel;
  logic load_reg, reg_sel, instr_done, halted;

  tiny8_control dut (
    .clk       (clk),
    .rst       (rst),
    .opcode    (opcode),
    .imm4      (imm4),
    .z_flag    (z_flag),
    .mem_resp  (mem_resp),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .addr_sel  (addr_sel),
    .load_ir   (load_ir),
    .load_pc   (load_pc),
    .pc_sel    (pc_sel),
    .load_reg  (load_reg),
    .reg_sel   (reg_sel),
    .instr_done(instr_done),
    .halted    (halted)
  );

  always #5 clk = ~clk;

  // Output vector: {mem_read, mem_write, addr_sel, load_ir, load_pc, pc_sel,
  //                 load_reg, reg_sel, instr_done, halted}
  localparam logic [9:0] B_MR   = 10'b10_0000_0000;
  localparam logic [9:0] B_MW   = 10'b01_0000_0000;
  localparam logic [9:0] B_AS   = 10'b00_1000_0000;
  localparam logic [9:0] B_IR   = 10'b00_0100_0000;
  localparam logic [9:0] B_LPC  = 10'b00_0010_0000;
  localparam logic [9:0] B_PSEL = 10'b00_0001_0000;
  localparam logic [9:0] B_LREG = 10'b00_0000_1000;
  localparam logic [9:0] B_RSEL = 10'b00_0000_0100;
  localparam logic [9:0] B_DONE = 10'b00_0000_0010;
  localparam logic [9:0] B_HALT = 10'b00_0000_0001;

  localparam logic [9:0] E_IDLE       = 10'b0;
  localparam logic [9:0] E_FETCH_WAIT = B_MR;
  localparam logic [9:0] E_FETCH_RESP = B_MR | B_IR | B_LPC;
  localparam logic [9:0] E_ADD        = B_LREG | B_DONE;
  localparam logic [9:0] E_LD_WAIT    = B_MR | B_AS;
  localparam logic [9:0] E_LD_RESP    = B_MR | B_AS | B_LREG | B_RSEL | B_DONE;
  localparam logic [9:0] E_ST_WAIT    = B_MW | B_AS;
  localparam logic [9:0] E_ST_RESP    = B_MW | B_AS | B_DONE;
  localparam logic [9:0] E_BR_TAKEN   = B_LPC | B_PSEL | B_DONE;
  localparam logic [9:0] E_BR_NOT     = B_DONE;

  logic [9:0] obs;
  assign obs = {mem_read, mem_write, addr_sel, load_ir, load_pc, pc_sel,
                load_reg, reg_sel, instr_done, halted};

  int unsigned total = 0;
  int unsigned bad = 0;
  logic [9:0] exp_q[$];

  task automatic check(input string tag, input logic [9:0] got, input logic [9:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %b want %b", tag, got, want);
    end
  endtask

  // One clock cycle: drive inputs just after a rising edge, score at the falling edge.
  task automatic step(input logic [1:0] op, input logic [3:0] imm, input logic z,
                      input logic resp, input logic [9:0] want, input string tag);
    opcode   = op;
    imm4     = imm;
    z_flag   = z;
    mem_resp = resp;
    exp_q.push_back(want);
    @(negedge clk);
    check(tag, obs, exp_q.pop_front());
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Held in reset: everything quiet.
    repeat (2) @(posedge clk);
    #1;
    check("reset_hold", obs, E_IDLE);
    rst = 1'b0;
    step(2'b00, 4'h0, 1'b0, 1'b0, E_FETCH_WAIT, "fetch_after_reset");

    // Async reset while a fetch is pending.
    rst = 1'b1;
    #1;
    check("rst_async_quiet", obs, E_IDLE);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(2'b00, 4'h0, 1'b0, 1'b0, E_FETCH_WAIT, "rst_release_fetch");

    // ADD, zero-wait fetch; late response after reset counts as the fetch response.
    step(2'b00, 4'h0, 1'b0, 1'b1, E_FETCH_RESP, "add_fetch");
    step(2'b00, 4'h0, 1'b0, 1'b0, E_IDLE,       "add_decode");
    step(2'b00, 4'h0, 1'b0, 1'b0, E_ADD,        "add_exec");
    step(2'b00, 4'h0, 1'b0, 1'b0, E_FETCH_WAIT, "add_refetch");

    // LD with three wait cycles on the data access.
    step(2'b01, 4'h0, 1'b0, 1'b1, E_FETCH_RESP, "ld_fetch");
    step(2'b01, 4'h0, 1'b0, 1'b0, E_IDLE,       "ld_decode");
    for (int i = 0; i < 3; i++) step(2'b01, 4'h0, 1'b0, 1'b0, E_LD_WAIT, "ld_wait");
    step(2'b01, 4'h0, 1'b0, 1'b1, E_LD_RESP,    "ld_resp");
    step(2'b01, 4'h0, 1'b0, 1'b0, E_FETCH_WAIT, "ld_refetch");

    // ST with a stray response during DECODE.
    step(2'b10, 4'h0, 1'b0, 1'b1, E_FETCH_RESP, "st_fetch");
    step(2'b10, 4'h0, 1'b0, 1'b1, E_IDLE,       "st_decode_spurious");
    for (int i = 0; i < 2; i++) step(2'b10, 4'h0, 1'b0, 1'b0, E_ST_WAIT, "st_wait");
    step(2'b10, 4'h0, 1'b0, 1'b1, E_ST_RESP,    "st_resp");
    step(2'b10, 4'h0, 1'b0, 1'b0, E_FETCH_WAIT, "st_refetch");

    // BR imm4=8, taken then not taken (stray response in BR must be ignored).
    step(2'b11, 4'h8, 1'b1, 1'b1, E_FETCH_RESP, "br_t_fetch");
    step(2'b11, 4'h8, 1'b1, 1'b0, E_IDLE,       "br_t_decode");
    step(2'b11, 4'h8, 1'b1, 1'b0, E_BR_TAKEN,   "br_taken");
    step(2'b11, 4'h8, 1'b0, 1'b1, E_FETCH_RESP, "br_n_fetch");
    step(2'b11, 4'h8, 1'b0, 1'b0, E_IDLE,       "br_n_decode");
    step(2'b11, 4'h8, 1'b0, 1'b1, E_BR_NOT,     "br_not_taken");
    step(2'b11, 4'h8, 1'b0, 1'b0, E_FETCH_WAIT, "br_refetch");

    // Branch-to-self with Z set.
    step(2'b11, 4'hF, 1'b1, 1'b1, E_FETCH_RESP, "self_fetch");
    step(2'b11, 4'hF, 1'b1, 1'b0, E_IDLE,       "self_decode");
`ifdef TINY8_CTRL_HALT_EN
    step(2'b11, 4'hF, 1'b1, 1'b0, E_BR_NOT,     "self_br_halting");
    for (int i = 0; i < 20; i++) step(2'b11, 4'hF, 1'b1, i[0], B_HALT, "halt_hold");
    rst = 1'b1;
    #1;
    check("halt_rst_quiet", obs, E_IDLE);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(2'b00, 4'h0, 1'b0, 1'b0, E_FETCH_WAIT, "halt_cleared_fetch");
`else
    step(2'b11, 4'hF, 1'b1, 1'b0, E_BR_TAKEN,   "self_br_loop");
    step(2'b11, 4'hF, 1'b1, 1'b0, E_FETCH_WAIT, "self_refetch");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
